// File: rtl/updown_sweep_pkg.sv
// updown_sweep_pkg: shared FSM state encoding and default dwell length for the sweep controller
package updown_sweep_pkg;
    typedef enum logic [2:0] {IDLE, UP, HOLD_HI, DOWN, HOLD_LO} state_t;
    localparam int HOLD_CYCLES_DEF = 2;
endpackage

// File: rtl/updown_cnt_core.sv
// updown_cnt_core: loadable up/down counter datapath
// Ports: clk, reset (async active-low) | load/load_val: synchronous load |
//        en: step enable | up_down: 1 = +1, 0 = -1 | count: current value
module updown_cnt_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_down,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb
        count_d = load ? load_val
                : en   ? (up_down ? count_q + WIDTH'(1) : count_q - WIDTH'(1))
                : count_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) count_q <= '0;
        else        count_q <= count_d;

    assign count = count_q;
endmodule

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: triangle sweep controller between latched lo/hi limits with dwell at each limit
// Ports: clk, reset (async active-low) | start/stop: one-cycle requests |
//        lo/hi/sweeps: run config sampled at accepted start (sweeps 0 = endless) |
//        count/dir: counter value and direction | busy: not IDLE | done/err: one-cycle pulses
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [3:0]       sweeps,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam bit         HAS_HOLD  = HOLD_CYCLES != 0;
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [3:0]       sweep_q, sweep_d, hold_q, hold_d;
    logic             dir_q, dir_d, done_q, done_d, err_q, err_d;
    logic             load, en, up;

    updown_cnt_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (lo),
        .en       (en),
        .up_down  (up),
        .count    (count)
    );

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        sweep_d = sweep_q;
        hold_d  = hold_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        en      = 1'b0;
        up      = 1'b1;
        // stop outranks everything; count and dir simply freeze
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start && !stop) begin
                    if (lo < hi) begin
                        lo_d    = lo;
                        hi_d    = hi;
                        sweep_d = sweeps;
                        load    = 1'b1;
                        dir_d   = 1'b1;
                        state_d = UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                UP: begin
                    en = 1'b1;
                    // decide on the edge where count becomes hi
                    if (count == hi_q - WIDTH'(1)) begin
                        hold_d  = '0;
                        state_d = HAS_HOLD ? HOLD_HI : DOWN;
                        dir_d   = HAS_HOLD;
                    end
                end
                HOLD_HI: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = DOWN;
                        dir_d   = 1'b0;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
                DOWN: begin
                    en = 1'b1;
                    up = 1'b0;
                    if (count == lo_q + WIDTH'(1)) begin
                        hold_d = '0;
                        // sweep_q == 0 means endless, so it never counts down
                        if (sweep_q == 4'd1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            if (sweep_q != 4'd0) sweep_d = sweep_q - 4'd1;
                            state_d = HAS_HOLD ? HOLD_LO : UP;
                            dir_d   = !HAS_HOLD;
                        end
                    end
                end
                HOLD_LO: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = UP;
                        dir_d   = 1'b1;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            sweep_q <= '0;
            hold_q  <= '0;
            dir_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            sweep_q <= sweep_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign dir  = dir_q;
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign err  = err_q;
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb_updown_sweep_ctrl: scoreboard bench comparing the sweep controller against a trajectory model
module tb_updown_sweep_ctrl;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, stop = 1'b0;
    logic [3:0] lo = '0, hi = '0, sweeps = '0;
    logic [3:0] count;
    logic       dir, busy, done, err;

    updown_sweep_ctrl #(.WIDTH(4), .HOLD_CYCLES(H)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .lo     (lo),
        .hi     (hi),
        .sweeps (sweeps),
        .count  (count),
        .dir    (dir),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {int c; bit d; bit b; bit dn;} ent_t;
    typedef struct {int c; bit d; bit b; bit dn; bit er;} exp_t;

    ent_t traj[$];
    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   m_cnt = 0, m_lo = 0, m_hi = 0, rem = 0;
    bit   m_dir = 1'b1, m_busy = 1'b0;

    function automatic void chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endfunction

    // appends every post-edge value of one full sweep (after the value lo)
    function automatic void gen_sweep();
        bit last = (rem == 1);
        if (rem > 1) rem--;
        for (int v = m_lo + 1; v < m_hi; v++) traj.push_back('{v, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i <= H; i++) traj.push_back('{m_hi, i != H, 1'b1, 1'b0});
        for (int v = m_hi - 1; v > m_lo; v--) traj.push_back('{v, 1'b0, 1'b1, 1'b0});
        if (last) traj.push_back('{m_lo, 1'b0, 1'b0, 1'b1});
        else for (int i = 0; i <= H; i++) traj.push_back('{m_lo, i == H, 1'b1, 1'b0});
    endfunction

    function automatic void model(input bit r, input bit s, input bit p, input int l, input int h, input int w);
        bit   dn = 1'b0, er = 1'b0;
        ent_t e;
        if (!r) begin
            traj.delete();
            m_cnt = 0; m_dir = 1'b1; m_busy = 1'b0;
        end else if (m_busy) begin
            if (p) begin
                traj.delete();
                m_busy = 1'b0;
            end else begin
                e = traj.pop_front();
                m_cnt = e.c; m_dir = e.d; m_busy = e.b; dn = e.dn;
                if (m_busy && traj.size() == 0) gen_sweep();
            end
        end else if (s && !p) begin
            if (l < h) begin
                m_lo = l; m_hi = h; rem = w;
                m_cnt = l; m_dir = 1'b1; m_busy = 1'b1;
                gen_sweep();
            end else begin
                er = 1'b1;
            end
        end
        exp_q.push_back('{m_cnt, m_dir, m_busy, dn, er});
    endfunction

    task automatic cyc(input bit r, input bit s, input bit p, input int l, input int h, input int w);
        bit fall;
        @(negedge clk);
        fall   = reset && !r;
        reset  = r;
        start  = s;
        stop   = p;
        lo     = 4'(l);
        hi     = 4'(h);
        sweeps = 4'(w);
        if (fall) begin
            #1;
            chk("async_rst_count", int'(count), 0);
            chk("async_rst_busy", int'(busy), 0);
            chk("async_rst_dir", int'(dir), 1);
        end
        model(r, s, p, l, h, w);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 0, 0, 0);
    endtask

    exp_t me;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            me = exp_q.pop_front();
            chk("count", int'(count), me.c);
            chk("dir", int'(dir), int'(me.d));
            chk("busy", int'(busy), int'(me.b));
            chk("done", int'(done), int'(me.dn));
            chk("err", int'(err), int'(me.er));
        end
    end

    initial begin
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
        idle(2);
        // single sweep 2..5
        cyc(1'b1, 1'b1, 1'b0, 2, 5, 1);
        idle(12);
        // equal limits rejected
        cyc(1'b1, 1'b1, 1'b0, 7, 7, 1);
        idle(3);
        // two full 0..15 triangles
        cyc(1'b1, 1'b1, 1'b0, 0, 15, 2);
        idle(75);
        // start and stop together in IDLE
        cyc(1'b1, 1'b1, 1'b1, 3, 9, 1);
        idle(3);
        // endless run aborted while count is 4 going up; start while busy ignored
        cyc(1'b1, 1'b1, 1'b0, 1, 9, 0);
        cyc(1'b1, 1'b1, 1'b0, 0, 3, 1);
        idle(2);
        cyc(1'b1, 1'b0, 1'b1, 0, 0, 0);
        idle(3);
        // asynchronous reset during HOLD_HI
        cyc(1'b1, 1'b1, 1'b0, 2, 5, 1);
        idle(4);
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
        idle(2);
        // randomized traffic
        for (int i = 0; i < 1500; i++)
            cyc(1'b1, $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        cyc(1'b1, 1'b0, 1'b1, 0, 0, 0);
        idle(2);
        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
